tlb_entry_file: RTL and testbench
=================================

TLB_ENTRY_FILE -- requirements
Module: tlb_entry_file

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of TLB entries (power of two, 2..64); IW = log2(ENTRIES).
REQ-002 SHALL have parameter PFN_W, default 20, meaning the PFN width per page (1..20).
REQ-003 SHALL have parameter ASID_W, default 8, meaning the ASID width (1..8).
REQ-004 SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit, a TLB command request.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
REQ-008 SHALL have port cmd_ready, output, 1 bit, which is high only in IDLE.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-010 SHALL have port mtc_we, input, 4 bits, one-hot CP0 write enable: bit0 Index, bit1 EntryLo0, bit2 EntryLo1, bit3 EntryHi.
REQ-011 SHALL have port mtc_data, input, 32 bits, the CP0 write data.
REQ-012 SHALL have ports index_q, entrylo0_q, entrylo1_q, entryhi_q and random_q, each output, 32 bits, the CP0 register readback.

Function
REQ-013 EntryLo format SHALL be {zeros, PFN[PFN_W-1:0] at bit 6 upward, 3'b0, D[2], V[1], G[0]}; mtc writes SHALL capture only these fields, and all other bits SHALL read 0.
REQ-014 EntryHi format SHALL be {VPN2[31:13], zeros, ASID[ASID_W-1:0]}; Index format SHALL be {P[31], zeros, idx[IW-1:0]}; an mtc to Index SHALL clear P.
REQ-015 Each entry SHALL hold VPN2, ASID, G, PFN0/D0/V0 and PFN1/D1/V1; the stored G SHALL be EntryLo0.G AND EntryLo1.G, and TLBR SHALL return the stored G in both G bits.
REQ-016 A command SHALL be accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-017 TLBWI SHALL write the entry at Index.idx on the accepting edge; TLBWR SHALL write the entry at random_q[IW-1:0]; TLBR SHALL load EntryHi, EntryLo0 and EntryLo1 from entry Index.idx.
REQ-018 For TLBR, TLBWI and TLBWR, done SHALL pulse in the cycle after acceptance, and the state SHALL remain IDLE.
REQ-019 The FSM SHALL have states IDLE and PROBE; TLBP acceptance SHALL move it IDLE->PROBE and clear scan counter k to 0.
REQ-020 In PROBE, each cycle SHALL compare entry k; a match is entry.VPN2==EntryHi.VPN2 and (entry.G or entry.ASID==EntryHi.ASID).
REQ-021 On a match, the block SHALL write Index={P=0, idx=k}, pulse done in the next cycle and return to IDLE; latency from acceptance SHALL be k+1 cycles.
REQ-022 If k=ENTRIES-1 does not match, the block SHALL set Index.P=1, keep idx unchanged, pulse done and return to IDLE (latency ENTRIES cycles).
REQ-023 The lowest-index match SHALL always win.
REQ-024 Random SHALL decrement every cycle and wrap from 0 to ENTRIES-1; it SHALL not be mtc-writable.
REQ-025 An mtc write in the same edge as command acceptance: the command SHALL use the pre-write register values; for TLBR, the TLBR load SHALL win over mtc to EntryLo0/EntryLo1/EntryHi.
REQ-026 mtc_we SHALL be ignored while in PROBE.
REQ-027 cmd_valid SHALL be ignored while cmd_ready=0, and no queuing SHALL occur.

Reset
REQ-028 On rst, all entries SHALL be zeroed (V0=V1=0); Index, EntryLo0, EntryLo1 and EntryHi SHALL be 0; random_q SHALL be ENTRIES-1; the state SHALL be IDLE; done SHALL be 0; cmd_ready SHALL be 1 in the following cycle.
REQ-029 rst during PROBE SHALL abort the probe without a done pulse or an Index update.

Configuration
REQ-030 Macro TLB_FAST_PROBE_EN, when defined: TLBP SHALL compare all entries in parallel in the accepting cycle, done SHALL pulse in the next cycle with lowest-index-wins and the same P/idx rules, and PROBE SHALL last exactly one cycle; when undefined, the sequential scan of REQ-019..REQ-022 SHALL apply.

Verification
REQ-031 Reset, then read all registers -> index_q=0, entrylo0_q=0, entrylo1_q=0, entryhi_q=0, random_q=15 (ENTRIES=16); random_q counts 14,13,...,0,15.
REQ-032 mtc EntryHi=0x00402005, EntryLo0=0x00001047, EntryLo1=0x00001086, Index=3; TLBWI; clear the registers; TLBR -> entryhi_q=0x00402005, entrylo0_q=0x00001046, entrylo1_q=0x00001086 (G=0 because EntryLo1.G=0).
REQ-033 Entry 5 written with the REQ-032 EntryHi, then TLBP with EntryHi=0x00402005 -> done at cycle 6 after acceptance (cycle 1 with TLB_FAST_PROBE_EN), index_q=0x00000005.
REQ-034 TLBP with EntryHi=0x7FFFE000 (no match) and Index=2 -> done at cycle 16, index_q=0x80000002.
REQ-035 Global entry (G=1) with ASID 0x05 at index 7 and at index 9; probe with ASID 0x33 -> match, index_q=0x00000007 (lowest-index wins); mtc_we asserted during PROBE has no effect.
REQ-036 Assert rst at cycle 3 of a TLBP -> no done pulse, index_q=0, cmd_ready=1 in the following cycle.

Source files
------------

// File: rtl/tlb_entry_file.sv
// tlb_entry_file
//   MIPS-style software-managed TLB entry file with its CP0 staging registers
//   (Index, EntryLo0, EntryLo1, EntryHi, Random) and the TLBR/TLBWI/TLBWR/TLBP
//   command engine.
//
//   Parameters
//     ENTRIES  number of TLB entries (power of two, 2..64)
//     PFN_W    PFN width per page (1..20)
//     ASID_W   ASID width (1..8)
//
//   Ports
//     clk, rst                 clock; synchronous active-high reset
//     cmd_valid, cmd_op[1:0]   command request: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
//     cmd_ready                high only while IDLE
//     done                     one-cycle completion pulse
//     mtc_we[3:0], mtc_data    one-hot CP0 write: Index, EntryLo0, EntryLo1, EntryHi
//     index_q, entrylo0_q,
//     entrylo1_q, entryhi_q,
//     random_q                 CP0 register readback
//
//   Configuration macro
//     TLB_FAST_PROBE_EN  when defined, TLBP compares all entries in parallel in
//                        the accepting cycle and PROBE lasts exactly one cycle;
//                        otherwise TLBP scans one entry per cycle.
//
//   Probe timing: in the PROBE cycle that concludes the search, done is raised
//   combinationally and Index is updated on the closing edge, so a match at
//   entry k shows done k+1 cycles after the accepting edge.

module tlb_entry_file #(
  parameter int ENTRIES = 16,
  parameter int PFN_W   = 20,
  parameter int ASID_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic        done,
  input  logic [3:0]  mtc_we,
  input  logic [31:0] mtc_data,
  output logic [31:0] index_q,
  output logic [31:0] entrylo0_q,
  output logic [31:0] entrylo1_q,
  output logic [31:0] entryhi_q,
  output logic [31:0] random_q
);

  localparam int IW = $clog2(ENTRIES);

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  typedef enum logic {IDLE, PROBE} state_t;
  state_t state_reg, state_next;

  // CP0 staging registers, stored as fields only
  logic             p_reg;
  logic [IW-1:0]    idx_reg;
  logic [PFN_W-1:0] pfn0_reg, pfn1_reg;
  logic             d0_reg, v0_reg, g0_reg;
  logic             d1_reg, v1_reg, g1_reg;
  logic [18:0]      vpn2_reg;
  logic [ASID_W-1:0] asid_reg;
  logic [IW-1:0]    rnd_reg;
  logic             done_reg;

  // TLB entry array
  logic [18:0]       e_vpn2 [ENTRIES];
  logic [ASID_W-1:0] e_asid [ENTRIES];
  logic              e_g    [ENTRIES];
  logic [PFN_W-1:0]  e_pfn0 [ENTRIES];
  logic              e_d0   [ENTRIES];
  logic              e_v0   [ENTRIES];
  logic [PFN_W-1:0]  e_pfn1 [ENTRIES];
  logic              e_d1   [ENTRIES];
  logic              e_v1   [ENTRIES];

  logic               accept;
  logic               probe_start;
  logic               probe_finish;
  logic               probe_hit;
  logic [IW-1:0]      probe_idx;
  logic [ENTRIES-1:0] wr_sel;
  logic               unused_mtc;

  genvar gi;

  assign accept      = cmd_valid && (state_reg == IDLE);
  assign probe_start = accept && (cmd_op == OP_TLBP);
  assign cmd_ready   = (state_reg == IDLE);
  // A reset edge cancels a concluding probe, so its done is masked as well.
  assign done        = done_reg || (probe_finish && !rst);
  // Only the architected fields of mtc_data are captured.
  assign unused_mtc  = ^mtc_data;

  // Entry write select: TLBWI targets Index.idx, TLBWR targets Random.
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_wr_sel
      assign wr_sel[gi] = accept &&
                          (((cmd_op == OP_TLBWI) && (idx_reg == IW'(gi))) ||
                           ((cmd_op == OP_TLBWR) && (rnd_reg == IW'(gi))));
    end
  endgenerate

`ifdef TLB_FAST_PROBE_EN
  // Parallel compare against the pre-write EntryHi in the accepting cycle;
  // the result is held for the single PROBE cycle.
  logic [ENTRIES-1:0] match_vec;
  logic               hit_any;
  logic [IW-1:0]      hit_idx;
  logic               hit_reg;
  logic [IW-1:0]      hit_idx_reg;

  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign match_vec[gi] = (e_vpn2[gi] == vpn2_reg) &&
                             (e_g[gi] || (e_asid[gi] == asid_reg));
    end
  endgenerate

  // Walk downward so the lowest matching index is the last one assigned.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_reg     <= 1'b0;
      hit_idx_reg <= '0;
    end else if (probe_start) begin
      hit_reg     <= hit_any;
      hit_idx_reg <= hit_idx;
    end
  end

  assign probe_finish = (state_reg == PROBE);
  assign probe_hit    = hit_reg;
  assign probe_idx    = hit_idx_reg;
`else
  // Sequential scan: one entry per PROBE cycle, key captured at acceptance so
  // the search is immune to later EntryHi changes.
  logic [IW-1:0]     k_reg;
  logic [18:0]       key_vpn2_reg;
  logic [ASID_W-1:0] key_asid_reg;

  assign probe_hit    = (state_reg == PROBE) &&
                        (e_vpn2[k_reg] == key_vpn2_reg) &&
                        (e_g[k_reg] || (e_asid[k_reg] == key_asid_reg));
  assign probe_finish = (state_reg == PROBE) &&
                        (probe_hit || (k_reg == IW'(ENTRIES - 1)));
  assign probe_idx    = k_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg        <= '0;
      key_vpn2_reg <= '0;
      key_asid_reg <= '0;
    end else if (probe_start) begin
      k_reg        <= '0;
      key_vpn2_reg <= vpn2_reg;
      key_asid_reg <= asid_reg;
    end else if (state_reg == PROBE) begin
      k_reg <= k_reg + IW'(1);
    end
  end
`endif

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (probe_start)  state_next = PROBE;
      PROBE:   if (probe_finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Entry storage; written from the pre-write staging registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_pfn0[i] <= '0;
        e_d0[i]   <= 1'b0;
        e_v0[i]   <= 1'b0;
        e_pfn1[i] <= '0;
        e_d1[i]   <= 1'b0;
        e_v1[i]   <= 1'b0;
      end else if (wr_sel[i]) begin
        e_vpn2[i] <= vpn2_reg;
        e_asid[i] <= asid_reg;
        e_g[i]    <= g0_reg && g1_reg;
        e_pfn0[i] <= pfn0_reg;
        e_d0[i]   <= d0_reg;
        e_v0[i]   <= v0_reg;
        e_pfn1[i] <= pfn1_reg;
        e_d1[i]   <= d1_reg;
        e_v1[i]   <= v1_reg;
      end
    end
  end

  // CP0 staging registers. Later assignments in this block take priority:
  // the TLBR load overrides a same-edge mtc, and the probe result updates Index.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg    <= 1'b0;
      idx_reg  <= '0;
      pfn0_reg <= '0;
      d0_reg   <= 1'b0;
      v0_reg   <= 1'b0;
      g0_reg   <= 1'b0;
      pfn1_reg <= '0;
      d1_reg   <= 1'b0;
      v1_reg   <= 1'b0;
      g1_reg   <= 1'b0;
      vpn2_reg <= '0;
      asid_reg <= '0;
      rnd_reg  <= IW'(ENTRIES - 1);
      done_reg <= 1'b0;
    end else begin
      rnd_reg  <= rnd_reg - IW'(1);
      done_reg <= accept && (cmd_op != OP_TLBP);

      if (state_reg == IDLE) begin
        if (mtc_we[0]) begin
          p_reg   <= 1'b0;
          idx_reg <= mtc_data[IW-1:0];
        end
        if (mtc_we[1]) begin
          pfn0_reg <= mtc_data[6 +: PFN_W];
          d0_reg   <= mtc_data[2];
          v0_reg   <= mtc_data[1];
          g0_reg   <= mtc_data[0];
        end
        if (mtc_we[2]) begin
          pfn1_reg <= mtc_data[6 +: PFN_W];
          d1_reg   <= mtc_data[2];
          v1_reg   <= mtc_data[1];
          g1_reg   <= mtc_data[0];
        end
        if (mtc_we[3]) begin
          vpn2_reg <= mtc_data[31:13];
          asid_reg <= mtc_data[ASID_W-1:0];
        end
      end

      if (accept && (cmd_op == OP_TLBR)) begin
        vpn2_reg <= e_vpn2[idx_reg];
        asid_reg <= e_asid[idx_reg];
        pfn0_reg <= e_pfn0[idx_reg];
        d0_reg   <= e_d0[idx_reg];
        v0_reg   <= e_v0[idx_reg];
        g0_reg   <= e_g[idx_reg];
        pfn1_reg <= e_pfn1[idx_reg];
        d1_reg   <= e_d1[idx_reg];
        v1_reg   <= e_v1[idx_reg];
        g1_reg   <= e_g[idx_reg];
      end

      if (probe_finish) begin
        if (probe_hit) begin
          p_reg   <= 1'b0;
          idx_reg <= probe_idx;
        end else begin
          p_reg <= 1'b1;
        end
      end
    end
  end

  // Readback assembly: unused bits read as zero.
  always_comb begin
    index_q             = '0;
    index_q[31]         = p_reg;
    index_q[IW-1:0]     = idx_reg;
    entrylo0_q          = '0;
    entrylo0_q[6 +: PFN_W] = pfn0_reg;
    entrylo0_q[2:0]     = {d0_reg, v0_reg, g0_reg};
    entrylo1_q          = '0;
    entrylo1_q[6 +: PFN_W] = pfn1_reg;
    entrylo1_q[2:0]     = {d1_reg, v1_reg, g1_reg};
    entryhi_q           = '0;
    entryhi_q[31:13]    = vpn2_reg;
    entryhi_q[ASID_W-1:0] = asid_reg;
    random_q            = '0;
    random_q[IW-1:0]    = rnd_reg;
  end

endmodule

// File: tb/tb_tlb_entry_file.sv
// Directed testbench for tlb_entry_file (ENTRIES=16, PFN_W=20, ASID_W=8).
// Expected command results are queued when a command is issued and popped
// when done is observed.

module tb_tlb_entry_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        done;
  logic [3:0]  mtc_we;
  logic [31:0] mtc_data;
  logic [31:0] index_q, entrylo0_q, entrylo1_q, entryhi_q, random_q;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_WI = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_P  = 2'b11;

  localparam logic [3:0] W_IDX = 4'b0001;
  localparam logic [3:0] W_LO0 = 4'b0010;
  localparam logic [3:0] W_LO1 = 4'b0100;
  localparam logic [3:0] W_HI  = 4'b1000;

  tlb_entry_file dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .done       (done),
    .mtc_we     (mtc_we),
    .mtc_data   (mtc_data),
    .index_q    (index_q),
    .entrylo0_q (entrylo0_q),
    .entrylo1_q (entrylo1_q),
    .entryhi_q  (entryhi_q),
    .random_q   (random_q)
  );

  always #5 clk = ~clk;

  // Reference Random counter
  logic [3:0] rnd_m;
  always @(posedge clk) begin
    if (rst) rnd_m <= 4'd15;
    else     rnd_m <= rnd_m - 4'd1;
  end

  typedef struct {
    string       tag;
    int          lat;
    bit          chk;
    logic [31:0] idx;
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } exp_t;

  exp_t       sb[$];
  int         passed = 0;
  int         total  = 0;
  logic [3:0] acc_rnd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic int plat(input int k);
`ifdef TLB_FAST_PROBE_EN
    return 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_R; mtc_we = 4'b0; mtc_data = 32'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic mtc(input logic [3:0] we, input logic [31:0] d);
    mtc_we = we; mtc_data = d;
    tick();
    mtc_we = 4'b0;
  endtask

  // Issue one command; optional mtc on the accepting edge, optional mtc and
  // held cmd_valid during the busy cycles that follow.
  task automatic run_cmd(input string tag, input logic [1:0] op, input int lat,
                         input bit chk, input logic [31:0] e_idx, input logic [31:0] e_hi,
                         input logic [31:0] e_lo0, input logic [31:0] e_lo1,
                         input logic [3:0] acc_we, input logic [31:0] acc_d,
                         input logic [3:0] prb_we, input logic [31:0] prb_d,
                         input bit hold_valid);
    exp_t e;
    int   n;
    bit   seen;
    e.tag = tag; e.lat = lat; e.chk = chk;
    e.idx = e_idx; e.hi = e_hi; e.lo0 = e_lo0; e.lo1 = e_lo1;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; mtc_we = acc_we; mtc_data = acc_d;
    acc_rnd = rnd_m;
    tick();
    cmd_valid = hold_valid;
    if (hold_valid) cmd_op = OP_WI;
    mtc_we = prb_we; mtc_data = prb_d;
    n = 1; seen = 1'b0;
    while (!seen && n <= 40) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    cmd_valid = 1'b0; mtc_we = 4'b0;
    e = sb.pop_front();
    check({e.tag, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(e.lat));
    tick();
    check({e.tag, "_done_low"}, {31'b0, done}, 32'h0);
    check({e.tag, "_ready"}, {31'b0, cmd_ready}, 32'h1);
    if (e.chk) begin
      check({e.tag, "_index"}, index_q, e.idx);
      check({e.tag, "_entryhi"}, entryhi_q, e.hi);
      check({e.tag, "_entrylo0"}, entrylo0_q, e.lo0);
      check({e.tag, "_entrylo1"}, entrylo1_q, e.lo1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          rst_cyc;

    // Reset state and Random countdown
    do_reset();
    check("rst_index", index_q, 32'h0);
    check("rst_lo0", entrylo0_q, 32'h0);
    check("rst_lo1", entrylo1_q, 32'h0);
    check("rst_hi", entryhi_q, 32'h0);
    check("rst_random", random_q, 32'd15);
    check("rst_ready", {31'b0, cmd_ready}, 32'h1);
    check("rst_done", {31'b0, done}, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("random_%0d", i), random_q, 32'((15 - i) & 15));
    end

    // Field masking of mtc writes
    mtc(W_HI, 32'hFFFF_FFFF);   check("mask_hi", entryhi_q, 32'hFFFF_E0FF);
    mtc(W_LO0, 32'hFFFF_FFFF);  check("mask_lo0", entrylo0_q, 32'h03FF_FFC7);
    mtc(W_IDX, 32'hFFFF_FFFF);  check("mask_index", index_q, 32'h0000_000F);

    // TLBWI entry 3, clear registers, TLBR with a competing EntryHi mtc
    mtc(W_HI, 32'h0040_2005); mtc(W_LO0, 32'h0000_1047);
    mtc(W_LO1, 32'h0000_1086); mtc(W_IDX, 32'd3);
    run_cmd("tlbwi3", OP_WI, 1, 1, 32'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_1086,
            4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    mtc(W_HI, 32'h0); mtc(W_LO0, 32'h0); mtc(W_LO1, 32'h0);
    run_cmd("tlbr3", OP_R, 1, 1, 32'd3, 32'h0040_2005, 32'h0000_1046, 32'h0000_1086,
            W_HI, 32'hFFFF_FFFF, 4'b0, 32'h0, 1'b0);

    // Probe hit at entry 5
    do_reset();
    mtc(W_HI, 32'h0040_2005); mtc(W_LO0, 32'h0000_1047);
    mtc(W_LO1, 32'h0000_1086); mtc(W_IDX, 32'd5);
    run_cmd("tlbwi5", OP_WI, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    mtc(W_IDX, 32'd0);
    run_cmd("tlbp_hit5", OP_P, plat(5), 1, 32'd5, 32'h0040_2005, 32'h0000_1047, 32'h0000_1086,
            4'b0, 32'h0, 4'b0, 32'h0, 1'b0);

    // Probe miss; a TLBWI held on cmd_valid while busy must be dropped
    mtc(W_HI, 32'h7FFF_E000); mtc(W_IDX, 32'd2);
    run_cmd("tlbp_miss", OP_P, plat(15), 1, 32'h8000_0002, 32'h7FFF_E000, 32'h0000_1047,
            32'h0000_1086, 4'b0, 32'h0, 4'b0, 32'h0, 1'b1);
    mtc(W_IDX, 32'd2);
    check("index_clears_p", index_q, 32'h0000_0002);
    run_cmd("tlbr2_untouched", OP_R, 1, 1, 32'd2, 32'h0, 32'h0, 32'h0,
            4'b0, 32'h0, 4'b0, 32'h0, 1'b0);

    // Global entries at 7 and 9, non-global same VPN at 4; probe other ASID
    do_reset();
    mtc(W_HI, 32'h0040_2005); mtc(W_LO0, 32'h0000_1047); mtc(W_LO1, 32'h0000_1086);
    mtc(W_IDX, 32'd4);
    run_cmd("tlbwi4", OP_WI, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    mtc(W_LO1, 32'h0000_1087); mtc(W_IDX, 32'd9);
    run_cmd("tlbwi9", OP_WI, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    mtc(W_IDX, 32'd7);
    run_cmd("tlbwi7", OP_WI, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    mtc(W_HI, 32'h0040_2033);
    run_cmd("tlbp_global", OP_P, plat(7), 1, 32'd7, 32'h0040_2033, 32'h0000_1047, 32'h0000_1087,
            4'b0, 32'h0, W_HI, 32'h1234_5678, 1'b0);
    run_cmd("tlbr7", OP_R, 1, 1, 32'd7, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087,
            4'b0, 32'h0, 4'b0, 32'h0, 1'b0);

    // TLBWR lands on the Random value of the accepting cycle
    mtc(W_HI, 32'h0080_4033); mtc(W_LO0, 32'h0000_2003); mtc(W_LO1, 32'h0000_0040);
    run_cmd("tlbwr", OP_WR, 1, 1, 32'd7, 32'h0080_4033, 32'h0000_2003, 32'h0000_0040,
            4'b0, 32'h0, 4'b0, 32'h0, 1'b0);
    r = {28'b0, acc_rnd};
    mtc(W_IDX, r);
    run_cmd("tlbr_random", OP_R, 1, 1, r, 32'h0080_4033, 32'h0000_2002, 32'h0000_0040,
            4'b0, 32'h0, 4'b0, 32'h0, 1'b0);

    // Reset during a probe aborts it
    do_reset();
    mtc(W_HI, 32'h7FFF_E000); mtc(W_IDX, 32'd2);
`ifdef TLB_FAST_PROBE_EN
    rst_cyc = 1;
`else
    rst_cyc = 3;
`endif
    cmd_valid = 1'b1; cmd_op = OP_P;
    tick();
    cmd_valid = 1'b0;
    check("abort_busy", {31'b0, cmd_ready}, 32'h0);
    for (int c = 1; c < rst_cyc; c++) begin
      check($sformatf("abort_done_c%0d", c), {31'b0, done}, 32'h0);
      tick();
    end
    rst = 1'b1;
    #1;
    check("abort_done_rst", {31'b0, done}, 32'h0);
    tick();
    rst = 1'b0;
    check("abort_done_after", {31'b0, done}, 32'h0);
    check("abort_index", index_q, 32'h0);
    check("abort_ready", {31'b0, cmd_ready}, 32'h1);
    check("abort_hi", entryhi_q, 32'h0);
    tick();
    check("abort_no_late_done", {31'b0, done}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
